// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and the CPU core.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } dmem_req_t;

  localparam logic [6:0]  LW  = 7'b0000011;
  localparam logic [6:0]  SW  = 7'b0100011;
  localparam logic [31:0] NOP = 32'h00000013;

endpackage

// File: rtl/dmem_array.sv
// Single-port DEPTH x 32 synchronous RAM with per-byte write enables.
module dmem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    wstrb,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (wstrb[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory responder with LATENCY wait states before each access.
// Define DMEM_ERR_EN to flag misaligned or out-of-range addresses via rsp_err.
//
// state  | meaning
// IDLE   | ready for a request; request captured on handshake
// WAIT   | counting down LATENCY wait states
// ACCESS | phase 0: RAM read/write; phase 1: capture read data, raise rsp_valid
// RESP   | holding the response until rsp_ready
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_t      state;
  dmem_req_t   req_q;
  logic [3:0]  cnt;
  logic        acc_phase;
  logic        acc_err;
  logic        ram_en;
  logic [31:0] ram_rdata;

  assign ram_en = (state == ACCESS) && !acc_phase;

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (req_q.we && !acc_err),
    .wstrb (req_q.wstrb),
    .addr  (req_q.addr[AW+1:2]),
    .wdata (req_q.wdata),
    .rdata (ram_rdata)
  );

`ifdef DMEM_ERR_EN
  assign acc_err = (req_q.addr[1:0] != 2'b00) || (req_q.addr[31:AW+2] != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_err <= 1'b0;
    else if (state == ACCESS && acc_phase) rsp_err <= acc_err;
  end
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_q.addr[31:AW+2], req_q.addr[1:0]};
  assign acc_err = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_q     <= '0;
      cnt       <= '0;
      acc_phase <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_q     <= '{we: req_we, addr: req_addr, wdata: req_wdata, wstrb: req_wstrb};
            req_ready <= 1'b0;
            if (LATENCY == 0) begin
              state <= ACCESS;
            end else begin
              cnt   <= CNT_INIT;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= ACCESS;
          else cnt <= cnt - 4'd1;
        end
        ACCESS: begin
          // Synchronous RAM: read data is only available the cycle after the access.
          if (!acc_phase) begin
            acc_phase <= 1'b1;
          end else begin
            acc_phase <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= (req_q.we || acc_err) ? '0 : ram_rdata;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 1, 0, 15) checked against a transaction-level model.
module tb_dmem_responder;

  localparam int NI = 3;
`ifdef DMEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid [NI];
  logic        req_ready [NI];
  logic        req_we    [NI];
  logic [31:0] req_addr  [NI];
  logic [31:0] req_wdata [NI];
  logic [3:0]  req_wstrb [NI];
  logic        rsp_valid [NI];
  logic        rsp_ready [NI];
  logic [31:0] rsp_rdata [NI];
  logic        rsp_err   [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dmem_responder #(
      .DEPTH   (1024),
      .LATENCY ((g == 0) ? 1 : ((g == 1) ? 0 : 15))
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_wstrb (req_wstrb[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g])
    );
  end

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 15);
  endfunction

  task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d: got %h, expected %h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding request, response LAT+2 edges after acceptance,
  // memory effect committed on edge LAT+1 after acceptance.
  bit          m_busy  [NI];
  int          m_age   [NI];
  logic        m_we    [NI];
  logic [31:0] m_addr  [NI];
  logic [31:0] m_wdata [NI];
  logic [3:0]  m_wstrb [NI];
  logic [31:0] m_data  [NI];
  logic        m_err   [NI];
  bit          m_dknown[NI];
  logic [31:0] m_mem   [NI][1024];
  bit          m_known [NI][1024];
  int          m_idx;
  bit          m_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NI; k++) begin
        m_busy[k] = 1'b0;
        m_age[k]  = 0;
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        if (m_busy[k]) begin
          if (m_age[k] >= lat_of(k) + 2 && rsp_ready[k]) begin
            m_busy[k] = 1'b0;
          end else begin
            if (m_age[k] == lat_of(k)) begin
              m_idx    = int'(m_addr[k] / 4) % 1024;
              m_e      = ERR_EN && ((m_addr[k] % 4) != 0 || m_addr[k] >= 32'd4096);
              m_err[k] = m_e;
              if (m_we[k]) begin
                m_data[k]   = 32'h0;
                m_dknown[k] = 1'b1;
                if (!m_e) begin
                  for (int b = 0; b < 4; b++)
                    if (m_wstrb[k][b]) m_mem[k][m_idx][8*b +: 8] = m_wdata[k][8*b +: 8];
                  if (m_wstrb[k] == 4'hF) m_known[k][m_idx] = 1'b1;
                end
              end else if (m_e) begin
                m_data[k]   = 32'h0;
                m_dknown[k] = 1'b1;
              end else begin
                m_data[k]   = m_mem[k][m_idx];
                m_dknown[k] = m_known[k][m_idx];
              end
            end
            m_age[k]++;
          end
        end else if (req_valid[k]) begin
          m_busy[k]  = 1'b1;
          m_age[k]   = 0;
          m_we[k]    = req_we[k];
          m_addr[k]  = req_addr[k];
          m_wdata[k] = req_wdata[k];
          m_wstrb[k] = req_wstrb[k];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        bit ev;
        ev = m_busy[k] && (m_age[k] >= lat_of(k) + 2);
        chk("req_ready", k, 32'(req_ready[k]), 32'(!m_busy[k]));
        chk("rsp_valid", k, 32'(rsp_valid[k]), 32'(ev));
        if (ev) begin
          chk("rsp_err", k, 32'(rsp_err[k]), 32'(m_err[k]));
          if (m_dknown[k]) chk("rsp_rdata", k, rsp_rdata[k], m_data[k]);
        end
      end
    end
  end

  task automatic drive_req(int k, logic we, logic [31:0] addr, logic [31:0] wdata, logic [3:0] wstrb);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_wstrb[k] = wstrb;
  endtask

  task automatic wait_accept(int k);
    bit acc;
    int tmo;
    acc = 1'b0;
    tmo = 0;
    while (!acc && tmo < 50) begin
      @(negedge clk);
      acc = req_ready[k];
      @(posedge clk);
      #1;
      tmo++;
    end
    req_valid[k] = 1'b0;
    if (!acc) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout inst%0d: no acceptance within 50 cycles", k);
    end
  endtask

  task automatic do_txn(int k, logic we, logic [31:0] addr, logic [31:0] wdata, logic [3:0] wstrb,
                        int hold, output logic [31:0] rdata, output logic err, output int lat);
    bit got;
    @(posedge clk);
    #1;
    rsp_ready[k] = 1'b0;
    drive_req(k, we, addr, wdata, wstrb);
    wait_accept(k);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 60) begin
      @(negedge clk);
      if (rsp_valid[k]) got = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    rdata = rsp_rdata[k];
    err   = rsp_err[k];
    if (!got) begin
      n_vec++;
      n_bad++;
      $display("FAIL rsp_timeout inst%0d: no response within 60 cycles", k);
      return;
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", k, 32'(rsp_valid[k]), 32'd1);
      chk("hold_rdata", k, rsp_rdata[k], rdata);
      chk("hold_req_ready", k, 32'(req_ready[k]), 32'd0);
    end
    rsp_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[k] = 1'b0;
    @(negedge clk);
    chk("post_hs_req_ready", k, 32'(req_ready[k]), 32'd1);
    chk("post_hs_rsp_valid", k, 32'(rsp_valid[k]), 32'd0);
  endtask

  task automatic present(int k, int i);
    if (i < 3) drive_req(k, 1'b1, 32'h100 + 32'(4*i), 32'hA5000000 | 32'(i), 4'hF);
    else       drive_req(k, 1'b0, 32'h100 + 32'(4*(i-3)), 32'h0, 4'h0);
  endtask

  task automatic b2b(int k);
    int n_acc, n_rsp, acc_cyc, cyc, i;
    bit acc_next, rsp_next;
    n_acc = 0; n_rsp = 0; acc_cyc = 0; cyc = 0; i = 0;
    @(posedge clk);
    #1;
    rsp_ready[k] = 1'b1;
    present(k, 0);
    while (n_rsp < 6 && cyc < 400) begin
      @(negedge clk);
      acc_next = req_valid[k] && req_ready[k];
      rsp_next = rsp_valid[k] && rsp_ready[k];
      if (rsp_next) chk("spacing", k, 32'(cyc - acc_cyc), 32'(lat_of(k) + 2));
      @(posedge clk);
      cyc++;
      if (acc_next) begin
        acc_cyc = cyc;
        n_acc++;
        i++;
      end
      if (rsp_next) n_rsp++;
      #1;
      if (acc_next) begin
        if (i < 6) present(k, i);
        else req_valid[k] = 1'b0;
      end
    end
    req_valid[k] = 1'b0;
    rsp_ready[k] = 1'b0;
    chk("b2b_accepted", k, 32'(n_acc), 32'd6);
    chk("b2b_responses", k, 32'(n_rsp), 32'd6);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic er;
    int lat;
    for (int k = 0; k < NI; k++) begin
      req_valid[k] = 1'b0;
      req_we[k]    = 1'b0;
      req_addr[k]  = '0;
      req_wdata[k] = '0;
      req_wstrb[k] = '0;
      rsp_ready[k] = 1'b0;
    end
    #1 rst_n = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("reset_req_ready", k, 32'(req_ready[k]), 32'd1);
      chk("reset_rsp_valid", k, 32'(rsp_valid[k]), 32'd0);
      chk("reset_rsp_rdata", k, rsp_rdata[k], 32'h0);
      chk("reset_rsp_err", k, 32'(rsp_err[k]), 32'd0);
    end
    chk_en = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Store then load, LATENCY=1
    do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
    chk("store_latency", 0, 32'(lat), 32'd3);
    chk("store_rdata_zero", 0, rd, 32'h0);
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    chk("load_latency", 0, 32'(lat), 32'd3);
    chk("load_rdata", 0, rd, 32'hDEADBEEF);

    // Byte lanes
    do_txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd, er, lat);
    do_txn(0, 1'b1, 32'h20, 32'h000000AA, 4'b0001, 0, rd, er, lat);
    do_txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat);
    chk("byte_lane", 0, rd, 32'h112233AA);

    // Backpressure for 5 cycles
    do_txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 5, rd, er, lat);
    chk("backpressure_rdata", 0, rd, 32'h112233AA);

    // Zero strobe store leaves memory unchanged; low address bits
    do_txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, rd, er, lat);
    do_txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat);
    chk("zero_strobe", 0, rd, 32'h112233AA);
    do_txn(0, 1'b0, 32'h23, 32'h0, 4'h0, 0, rd, er, lat);
    chk("unaligned_rdata", 0, rd, ERR_EN ? 32'h0 : 32'h112233AA);
    chk("unaligned_err", 0, 32'(er), 32'(ERR_EN));

    // Reset while a store waits
    do_txn(0, 1'b1, 32'h40, 32'h0, 4'hF, 0, rd, er, lat);
    @(posedge clk);
    #1;
    drive_req(0, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF);
    wait_accept(0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    do_txn(0, 1'b0, 32'h40, 32'h0, 4'h0, 0, rd, er, lat);
    chk("reset_drop_store", 0, rd, 32'h0);

    // Error cases / index wrap
    do_txn(0, 1'b0, 32'h13, 32'h0, 4'h0, 0, rd, er, lat);
    chk("load13_err", 0, 32'(er), 32'(ERR_EN));
    chk("load13_rdata", 0, rd, ERR_EN ? 32'h0 : 32'hDEADBEEF);
    do_txn(0, 1'b1, 32'h0, 32'h0BAD0000, 4'hF, 0, rd, er, lat);
    do_txn(0, 1'b1, 32'h1000, 32'h5A5A5A5A, 4'hF, 0, rd, er, lat);
    chk("wrap_store_err", 0, 32'(er), 32'(ERR_EN));
    do_txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er, lat);
    chk("wrap_word0", 0, rd, ERR_EN ? 32'h0BAD0000 : 32'h5A5A5A5A);
    chk("wrap_load_err", 0, 32'(er), 32'd0);

    // Back-to-back sweeps
    b2b(1);
    b2b(2);
    b2b(0);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
